// File: rtl/hdlverifier_capture_pkg.sv
// hdlverifier_capture_pkg: state encoding and default geometry shared by the capture sequencer
package hdlverifier_capture_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH = 2 ** ADDR_WIDTH_DEF;
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_READOUT} state_t;
endpackage

// File: rtl/hdlverifier_dcram.sv
// hdlverifier_dcram: simple dual-port sample RAM; registered read output holds while rd is low
module hdlverifier_dcram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_wclk,
    input  logic                  i_wr,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rclk,
    input  logic                  i_rd,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge i_wclk) begin
        if (i_wr) r_mem[i_waddr] <= i_wdata;
    end
    always_ff @(posedge i_rclk) begin
        if (i_rd) o_q <= r_mem[i_raddr];
    end
endmodule

// File: rtl/hdlverifier_capture_ctrl.sv
// hdlverifier_capture_ctrl: trigger/capture sequencer that fills a circular sample buffer
// around a trigger and streams the whole buffer out oldest-first on a valid/ready port
module hdlverifier_capture_ctrl
    import hdlverifier_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_cfg_pretrig,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_din_valid,
    input  logic                  i_trig_in,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_valid,
    input  logic                  i_dout_ready,
    output logic                  o_dout_last,
    output logic                  o_busy,
    output logic                  o_triggered,
    output logic                  o_done
);
    localparam logic [ADDR_WIDTH:0] L_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] L_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, r_pt, r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH:0]   r_post, r_rem, w_post_trig, w_post_nxt;
    logic                  r_dout_valid, r_dout_last, r_triggered, r_done;
    logic                  w_acc, w_trig, w_beat, w_ram_rd;
    logic [DATA_WIDTH-1:0] w_q;
    always_comb begin
        w_acc = i_din_valid && !i_abort && !i_reset &&
                (r_state == S_PRE || r_state == S_ARMED || r_state == S_POST);
        w_trig = w_acc && i_trig_in && r_state == S_ARMED;
        w_beat = r_dout_valid && i_dout_ready;
        w_ram_rd = r_state == S_READOUT && r_rem != '0 && (!r_dout_valid || i_dout_ready) &&
                   !i_abort && !i_reset;
        w_cnt_nxt = r_cnt + 1'b1;
        w_post_trig = L_DEPTH - {1'b0, r_pt} - 1'b1;
        w_post_nxt = r_post - 1'b1;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_arm) w_state_nxt = (i_cfg_pretrig != '0) ? S_PRE : S_ARMED;
            S_PRE:     if (w_acc && w_cnt_nxt == r_pt) w_state_nxt = S_ARMED;
            S_ARMED:   if (w_trig) w_state_nxt = (w_post_trig == '0) ? S_READOUT : S_POST;
            S_POST:    if (w_acc && w_post_nxt == '0) w_state_nxt = S_READOUT;
            S_READOUT: if (w_beat && r_dout_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (i_abort) w_state_nxt = S_IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pt         <= '0;
            r_cnt        <= '0;
            r_post       <= '0;
            r_rem        <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == S_IDLE && i_arm) begin
                r_pt  <= i_cfg_pretrig;
                r_cnt <= '0;
            end
            if (r_state == S_PRE && w_acc) r_cnt <= w_cnt_nxt;
            // readout start is fixed at trigger time: the oldest retained sample is pt behind it
            if (w_trig) begin
                r_post   <= w_post_trig;
                r_rd_ptr <= r_wr_ptr - r_pt;
                r_rem    <= L_DEPTH;
            end
            if (r_state == S_POST && w_acc) r_post <= w_post_nxt;
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rem    <= r_rem - 1'b1;
            end
            r_dout_valid <= !i_abort && (w_ram_rd || (r_dout_valid && !i_dout_ready));
            r_dout_last  <= !i_abort && (w_ram_rd ? r_rem == L_ONE : r_dout_last && !w_beat);
            r_triggered  <= w_state_nxt != S_IDLE && (r_triggered || w_trig);
            r_done       <= !i_abort && w_beat && r_dout_last;
        end
    end
    hdlverifier_dcram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_wclk (i_clk),
        .i_wr   (w_acc),
        .i_waddr(r_wr_ptr),
        .i_wdata(i_din),
        .i_rclk (i_clk),
        .i_rd   (w_ram_rd),
        .i_raddr(r_rd_ptr),
        .o_q    (w_q)
    );
    assign o_dout       = w_q;
    assign o_dout_valid = r_dout_valid;
    assign o_dout_last  = r_dout_last;
    assign o_busy       = r_state != S_IDLE;
    assign o_triggered  = r_triggered;
    assign o_done       = r_done;
endmodule
